zulu_mac_tx: RTL and testbench
==============================

ZULU_MAC_TX -- requirements
Module: zulu_mac_tx

Interface
REQ-001 Parameter MAC_ORDERING, default 1, MAC byte order on mac_tx: 0 = first byte on [63:56], 1 = first byte on [7:0].
REQ-002 Parameter DEPTH_LOG2, default 9, log2 of data buffer depth in 64-bit words.
REQ-003 Parameter FRAMES_LOG2, default 4, log2 of the maximum number of committed frames held.
REQ-004 clk  in  1  processing clock; all logic synchronous to its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 in_data  in  64; in_keep  in  8; in_last  in  1; in_user  in  1 (abort frame); in_valid  in  1; in_ready  out  1: internal AXI-stream, first byte on [7:0].
REQ-007 mac_tx  out  64; mac_tx_keep  out  8; mac_tx_last  out  1; mac_tx_valid  out  1; mac_tx_ready  in  1: AXI-stream to MAC.
REQ-008 tx_drop  out  1  one-cycle pulse per discarded frame.
REQ-009 tx_level  out  DEPTH_LOG2+1  words held in the buffer.
REQ-010 stat_rst  in  1; stat_tx_frames  out  32; stat_tx_drops  out  32.

Function
REQ-011 Store-and-forward: a frame is transmitted only after its last beat is committed.
REQ-012 Input beat accepted when in_valid and in_ready; in_ready = buffer not full and frame count < 2^FRAMES_LOG2.
REQ-013 Writer FSM ACCEPT/DISCARD; ACCEPT writes beats; in_last with in_user=0 commits the frame (frame count +1, commit pointer = write pointer).
REQ-014 In ACCEPT, in_last with in_user=1 rewinds write pointer to commit pointer and pulses tx_drop; FSM stays in ACCEPT.
REQ-015 Buffer full mid-frame (frame with at least one beat written): rewind write pointer, go to DISCARD, keep in_ready=1 while in DISCARD and discard beats; pulse tx_drop on the in_last beat, then return to ACCEPT.
REQ-016 Reader FSM IDLE/SEND; IDLE->SEND when frame count > 0; SEND->IDLE on the mac_tx_last handshake, frame count -1.
REQ-017 Commit and frame completion in the same cycle leave frame count unchanged.
REQ-018 Outputs registered; first word of a frame shows on mac_tx_valid 2 cycles after its last input beat is accepted, if the reader is idle.
REQ-019 While mac_tx_valid=1 and mac_tx_ready=0, mac_tx, mac_tx_keep and mac_tx_last hold stable.
REQ-020 Back-to-back frames: no idle cycle between mac_tx_last of frame N and the first beat of frame N+1 when N+1 is already committed.
REQ-021 MAC_ORDERING=0: byte i of the input word goes to byte 7-i of mac_tx, and keep bits are reversed the same way; MAC_ORDERING=1: passes through unchanged.
REQ-022 Pointers wrap modulo 2^DEPTH_LOG2 and use one extra bit for full/empty detection; tx_level = write pointer minus read pointer.

Reset
REQ-023 rst=0 clears pointers, frame count and statistics, puts both FSMs in their first state (ACCEPT, IDLE), and sets in_ready, mac_tx_valid, mac_tx_last, tx_drop and tx_level to 0 and mac_tx and mac_tx_keep to 0.
REQ-024 Reset mid-frame discards all buffered and partial frames; no beat is emitted after reset until a new frame is committed.

Configuration
REQ-025 With ZULU_MAC_TX_STAT_EN defined, stat_tx_frames increments on each mac_tx_last handshake, stat_tx_drops increments on each tx_drop pulse, both saturate at 2^32-1, and stat_rst=1 clears them synchronously.
REQ-026 Without ZULU_MAC_TX_STAT_EN, stat_tx_frames and stat_tx_drops are constant 0, stat_rst is ignored, and no counter logic is built.

Structure
REQ-027 Package zulu_pkg holds MAC_W=64, KEEP_W=8, and a packed beat typedef {data, keep, last} shared with the RX side.
REQ-028 Data storage is one sub-module, zulu_sdp_ram: simple dual-port, 1-cycle read latency, width 73 bits.

Verification
REQ-029 One 3-beat frame, last keep=8'h0F, ready=1 -> mac_tx_valid 2 cycles after the last input beat; 3 beats out with keep FF,FF,0F.
REQ-030 Frame with in_user=1 on its last beat -> no output, one tx_drop pulse, tx_level back to 0.
REQ-031 DEPTH_LOG2=4 with a 20-beat frame -> in_ready stays 1, frame discarded, tx_drop pulses once on the last beat, next 2-beat frame is sent intact.
REQ-032 mac_tx_ready toggles 1,0,0,1 during a frame -> data held while stalled, beat order preserved, no duplicates.
REQ-033 MAC_ORDERING=0, input 64'h0807060504030201 with keep=8'h03 -> mac_tx=64'h0102030405060708, keep=8'hC0.
REQ-034 rst=0 asserted mid-transmit -> mac_tx_valid=0 on the next cycle; after release stat counters read 0 and nothing is emitted until a new frame is committed.

Source files
------------

// File: rtl/zulu_pkg.sv
// zulu_pkg: types and constants shared by the zulu MAC TX and RX sides.
//   MAC_W / KEEP_W : datapath and byte-enable widths.
//   beat_t         : one stored stream beat {data, keep, last} (73 bits).
//   wr_state_t / rd_state_t : writer and reader FSM encodings of the TX buffer.
//   swap_bytes / rev_keep   : byte-order reversal helpers for the MAC side.
package zulu_pkg;

  localparam int MAC_W  = 64;
  localparam int KEEP_W = 8;

  typedef struct packed {
    logic [MAC_W-1:0]  data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  typedef enum logic {
    WR_ACCEPT  = 1'b0,
    WR_DISCARD = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_t;

  // Byte i of the input moves to byte KEEP_W-1-i.
  function automatic logic [MAC_W-1:0] swap_bytes(input logic [MAC_W-1:0] d);
    logic [MAC_W-1:0] r;
    for (int i = 0; i < KEEP_W; i++) begin
      r[8*i +: 8] = d[8*(KEEP_W-1-i) +: 8];
    end
    return r;
  endfunction

  // Keep bit i moves to bit KEEP_W-1-i, matching swap_bytes.
  function automatic logic [KEEP_W-1:0] rev_keep(input logic [KEEP_W-1:0] k);
    logic [KEEP_W-1:0] r;
    for (int i = 0; i < KEEP_W; i++) begin
      r[i] = k[KEEP_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/zulu_sdp_ram.sv
// zulu_sdp_ram: simple dual-port RAM, one write port and one read port,
// registered read data (1-cycle latency). rd_data only changes on rd_en,
// so a word that was read stays available until the next read.
//   clk     : clock
//   wr_en   : write strobe, wr_addr / wr_data : write address / data
//   rd_en   : read strobe,  rd_addr : read address
//   rd_data : registered read data
module zulu_sdp_ram
  import zulu_pkg::*;
#(
  parameter int AW = 9,
  parameter int W  = BEAT_W
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/zulu_mac_tx.sv
// zulu_mac_tx: store-and-forward transmit buffer between the internal
// AXI-stream and the MAC. A frame leaves only once its last beat is
// committed; aborted (in_user on last) and oversized frames are dropped.
//
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   in_data/keep/last/user/valid, in_ready : input stream (first byte [7:0]),
//                              in_user on the last beat aborts the frame
//   mac_tx/keep/last/valid, mac_tx_ready   : registered output stream to MAC
//   tx_drop                  : one-cycle pulse per discarded frame
//   tx_level                 : words held in the buffer (write - read pointer)
//   stat_rst, stat_tx_frames, stat_tx_drops : statistics
//
// Build option: define ZULU_MAC_TX_STAT_EN to build the saturating frame and
// drop counters; otherwise both statistics read constant 0.
//
// Handshake rule on both streams: a beat transfers on a rising edge where
// valid and ready are both 1; a source holds its beat stable until then.
module zulu_mac_tx
  import zulu_pkg::*;
#(
  parameter int MAC_ORDERING = 1,
  parameter int DEPTH_LOG2   = 9,
  parameter int FRAMES_LOG2  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MAC_W-1:0]      in_data,
  input  logic [KEEP_W-1:0]     in_keep,
  input  logic                  in_last,
  input  logic                  in_user,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [MAC_W-1:0]      mac_tx,
  output logic [KEEP_W-1:0]     mac_tx_keep,
  output logic                  mac_tx_last,
  output logic                  mac_tx_valid,
  input  logic                  mac_tx_ready,
  output logic                  tx_drop,
  output logic [DEPTH_LOG2:0]   tx_level,
  input  logic                  stat_rst,
  output logic [31:0]           stat_tx_frames,
  output logic [31:0]           stat_tx_drops
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam int FW = FRAMES_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH      = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [FW-1:0] MAX_FRAMES = {1'b1, {FRAMES_LOG2{1'b0}}};

  wr_state_t wr_state, wr_state_next;
  rd_state_t rd_state, rd_state_next;

  logic [PW-1:0] wr_ptr, wr_ptr_next;
  logic [PW-1:0] commit_ptr, commit_ptr_next;
  logic [PW-1:0] rd_ptr;
  logic [FW-1:0] frame_cnt;

  logic full, partial, accept, wr_en, commit, drop_next;
  logic rd_en, q_valid, load, done;
  beat_t wr_beat, rd_beat;
  logic [MAC_W-1:0]  out_data;
  logic [KEEP_W-1:0] out_keep;

  assign tx_level = wr_ptr - rd_ptr;
  assign full     = (tx_level == DEPTH);
  assign partial  = (wr_ptr != commit_ptr);

  // When the buffer fills under a partial frame, keep accepting: the beat
  // that would overflow is swallowed and the rest of the frame is discarded.
  always_comb begin
    in_ready = rst && ((wr_state == WR_DISCARD) ||
                       ((frame_cnt < MAX_FRAMES) && (!full || partial)));
  end

  assign accept = in_valid && in_ready;

  assign wr_beat.data = in_data;
  assign wr_beat.keep = in_keep;
  assign wr_beat.last = in_last;

  // Writer FSM: next state and pointer updates.
  always_comb begin
    wr_state_next   = wr_state;
    wr_ptr_next     = wr_ptr;
    commit_ptr_next = commit_ptr;
    wr_en           = 1'b0;
    commit          = 1'b0;
    drop_next       = 1'b0;
    case (wr_state)
      WR_ACCEPT: begin
        if (accept) begin
          if (full) begin
            wr_ptr_next = commit_ptr;
            if (in_last) begin
              drop_next = 1'b1;
            end else begin
              wr_state_next = WR_DISCARD;
            end
          end else if (in_last && in_user) begin
            wr_ptr_next = commit_ptr;
            drop_next   = 1'b1;
          end else begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr + PW'(1);
            if (in_last) begin
              commit_ptr_next = wr_ptr + PW'(1);
              commit          = 1'b1;
            end
          end
        end
      end
      WR_DISCARD: begin
        if (accept && in_last) begin
          drop_next     = 1'b1;
          wr_state_next = WR_ACCEPT;
        end
      end
      default: wr_state_next = WR_ACCEPT;
    endcase
  end

  // Reader pipeline: RAM read stage (q_valid) feeding the output register.
  // Reads are bounded by commit_ptr, so only whole committed frames are
  // fetched, and the next frame can be prefetched behind the current one.
  assign done  = mac_tx_valid && mac_tx_ready && mac_tx_last;
  assign load  = q_valid && (!mac_tx_valid || mac_tx_ready);
  assign rd_en = (rd_ptr != commit_ptr) && (!q_valid || load);

  // Reader FSM: tracks whether a committed frame is being sent.
  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      RD_IDLE: if (frame_cnt != '0) rd_state_next = RD_SEND;
      RD_SEND: if (done) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    if (MAC_ORDERING == 0) begin
      out_data = swap_bytes(rd_beat.data);
      out_keep = rev_keep(rd_beat.keep);
    end else begin
      out_data = rd_beat.data;
      out_keep = rd_beat.keep;
    end
  end

  zulu_sdp_ram #(
    .AW (DEPTH_LOG2),
    .W  (BEAT_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data (wr_beat),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_data (rd_beat)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_state   <= WR_ACCEPT;
      rd_state   <= RD_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      frame_cnt  <= '0;
      q_valid    <= 1'b0;
      tx_drop    <= 1'b0;
    end else begin
      wr_state   <= wr_state_next;
      rd_state   <= rd_state_next;
      wr_ptr     <= wr_ptr_next;
      commit_ptr <= commit_ptr_next;
      frame_cnt  <= frame_cnt + FW'(commit) - FW'(done);
      tx_drop    <= drop_next;
      if (rd_en) begin
        rd_ptr  <= rd_ptr + PW'(1);
        q_valid <= 1'b1;
      end else if (load) begin
        q_valid <= 1'b0;
      end
    end
  end

  // Output register: holds its contents while stalled by mac_tx_ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mac_tx       <= '0;
      mac_tx_keep  <= '0;
      mac_tx_last  <= 1'b0;
      mac_tx_valid <= 1'b0;
    end else if (load) begin
      mac_tx       <= out_data;
      mac_tx_keep  <= out_keep;
      mac_tx_last  <= rd_beat.last;
      mac_tx_valid <= 1'b1;
    end else if (mac_tx_ready) begin
      mac_tx_valid <= 1'b0;
    end
  end

`ifdef ZULU_MAC_TX_STAT_EN
  logic [31:0] frames_q, drops_q;

  always_ff @(posedge clk) begin
    if (!rst || stat_rst) begin
      frames_q <= '0;
      drops_q  <= '0;
    end else begin
      if (done && (frames_q != '1)) frames_q <= frames_q + 32'd1;
      if (tx_drop && (drops_q != '1)) drops_q <= drops_q + 32'd1;
    end
  end

  assign stat_tx_frames = frames_q;
  assign stat_tx_drops  = drops_q;
`else
  logic unused_stat_rst;
  assign unused_stat_rst = stat_rst;
  assign stat_tx_frames  = '0;
  assign stat_tx_drops   = '0;
`endif

endmodule

// File: tb/tb_zulu_mac_tx.sv
// tb_zulu_mac_tx: directed bench for zulu_mac_tx (DEPTH_LOG2=4). A second
// instance with MAC_ORDERING=0 shares the inputs for the byte-order check.
module tb_zulu_mac_tx;
  import zulu_pkg::*;

  localparam int W = 73;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] in_data = '0;
  logic [7:0]  in_keep = '0;
  logic        in_last = 1'b0, in_user = 1'b0, in_valid = 1'b0;
  logic        mac_tx_ready = 1'b0, stat_rst = 1'b0;

  logic        in_ready, mac_tx_last, mac_tx_valid, tx_drop;
  logic [63:0] mac_tx;
  logic [7:0]  mac_tx_keep;
  logic [4:0]  tx_level;
  logic [31:0] stat_tx_frames, stat_tx_drops;

  logic        in_ready_b, mac_tx_last_b, mac_tx_valid_b, tx_drop_b;
  logic [63:0] mac_tx_b;
  logic [7:0]  mac_tx_keep_b;
  logic [4:0]  tx_level_b;
  logic [31:0] stat_tx_frames_b, stat_tx_drops_b;

  zulu_mac_tx #(.MAC_ORDERING(1), .DEPTH_LOG2(4), .FRAMES_LOG2(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .in_user(in_user), .in_valid(in_valid), .in_ready(in_ready), .mac_tx(mac_tx),
    .mac_tx_keep(mac_tx_keep), .mac_tx_last(mac_tx_last), .mac_tx_valid(mac_tx_valid),
    .mac_tx_ready(mac_tx_ready), .tx_drop(tx_drop), .tx_level(tx_level),
    .stat_rst(stat_rst), .stat_tx_frames(stat_tx_frames), .stat_tx_drops(stat_tx_drops)
  );

  zulu_mac_tx #(.MAC_ORDERING(0), .DEPTH_LOG2(4), .FRAMES_LOG2(4)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .in_user(in_user), .in_valid(in_valid), .in_ready(in_ready_b), .mac_tx(mac_tx_b),
    .mac_tx_keep(mac_tx_keep_b), .mac_tx_last(mac_tx_last_b), .mac_tx_valid(mac_tx_valid_b),
    .mac_tx_ready(mac_tx_ready), .tx_drop(tx_drop_b), .tx_level(tx_level_b),
    .stat_rst(stat_rst), .stat_tx_frames(stat_tx_frames_b), .stat_tx_drops(stat_tx_drops_b)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int drop_cnt = 0;
  int exp_frames = 0;
  int exp_drops = 0;

  always @(negedge clk) begin
    if (rst && mac_tx_valid && mac_tx_ready) obs_q.push_back({mac_tx, mac_tx_keep, mac_tx_last});
    if (rst && tx_drop) drop_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic u, output int waits);
    in_data = d; in_keep = k; in_last = l; in_user = u; in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_user = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [63:0] base, input logic [7:0] last_keep,
                            input logic user, input logic push, output int waits);
    int w;
    waits = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] k;
      logic l;
      l = (i == n - 1);
      k = l ? last_keep : 8'hFF;
      drive_beat(base + 64'(i), k, l, l && user, w);
      waits += w;
      if (push) exp_q.push_back({base + 64'(i), k, l});
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    drop_cnt = 0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !mac_tx_valid; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_obs();
    for (int i = 0; i < 100 && obs_q.size() < exp_q.size(); i++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, mac_tx_valid, mac_tx_last, tx_drop} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 0000", {in_ready, mac_tx_valid, mac_tx_last, tx_drop});
    end
    vectors++;
    if ({mac_tx, mac_tx_keep, tx_level} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got %h/%h/%0d want 0", mac_tx, mac_tx_keep, tx_level);
    end
    vectors++;
    if ({stat_tx_frames, stat_tx_drops} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_stats got %0d/%0d want 0/0", stat_tx_frames, stat_tx_drops);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    int w;
    logic [W-1:0] got;
    clear_sb();
    mac_tx_ready = 1'b1;
    send_frame(3, 64'h1111_0000_0000_0000, 8'h0F, 1'b0, 1'b1, w);
    exp_frames++;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (mac_tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_lat1 got %b want 0", mac_tx_valid);
    end
    @(negedge clk);
    vectors++;
    if (mac_tx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_lat2 got %b want 1", mac_tx_valid);
    end
    @(posedge clk); #1;
    wait_obs();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++;
        $display("FAIL single_beat%0d got %h want %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_drop();
    int w;
    clear_sb();
    mac_tx_ready = 1'b1;
    send_frame(2, 64'h2222_0000_0000_0000, 8'hFF, 1'b1, 1'b0, w);
    exp_drops++;
    @(negedge clk);
    vectors++;
    if (tx_drop !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_pulse got %b want 1", tx_drop);
    end
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (drop_cnt != 1 || obs_q.size() != 0 || tx_level !== 5'd0) begin
      miscompares++;
      $display("FAIL drop_after got drops=%0d beats=%0d level=%0d want 1/0/0",
               drop_cnt, obs_q.size(), tx_level);
    end
  endtask

  task automatic test_overflow();
    int w;
    logic [W-1:0] got;
    clear_sb();
    mac_tx_ready = 1'b1;
    send_frame(20, 64'h3333_0000_0000_0000, 8'hFF, 1'b0, 1'b0, w);
    exp_drops++;
    vectors++;
    if (w != 0) begin
      miscompares++;
      $display("FAIL ovf_ready_waits got %0d want 0", w);
    end
    @(negedge clk);
    vectors++;
    if (tx_drop !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_drop_on_last got %b want 1", tx_drop);
    end
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (drop_cnt != 1 || obs_q.size() != 0 || tx_level !== 5'd0) begin
      miscompares++;
      $display("FAIL ovf_after got drops=%0d beats=%0d level=%0d want 1/0/0",
               drop_cnt, obs_q.size(), tx_level);
    end
    send_frame(2, 64'h4444_0000_0000_0000, 8'h01, 1'b0, 1'b1, w);
    exp_frames++;
    wait_obs();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL ovf_next_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++;
        $display("FAIL ovf_next_beat%0d got %h want %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    int w;
    int pat[8] = '{1, 0, 0, 1, 1, 1, 1, 1};
    logic [W-1:0] got, prev;
    logic prev_valid, prev_ready;
    clear_sb();
    mac_tx_ready = 1'b0;
    send_frame(4, 64'h5555_0000_0000_0000, 8'h7F, 1'b0, 1'b1, w);
    exp_frames++;
    wait_valid();
    vectors++;
    if (mac_tx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_start got %b want 1", mac_tx_valid);
    end
    prev_valid = 1'b0; prev_ready = 1'b1; prev = '0;
    for (int s = 0; s < 8; s++) begin
      mac_tx_ready = pat[s][0];
      @(negedge clk);
      if (prev_valid && !prev_ready) begin
        vectors++;
        if ({mac_tx, mac_tx_keep, mac_tx_last} !== prev || mac_tx_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_hold%0d got %h want %h", s, {mac_tx, mac_tx_keep, mac_tx_last}, prev);
        end
      end
      prev = {mac_tx, mac_tx_keep, mac_tx_last};
      prev_valid = mac_tx_valid;
      prev_ready = mac_tx_ready;
      @(posedge clk); #1;
    end
    mac_tx_ready = 1'b1;
    wait_obs();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++;
        $display("FAIL stall_beat%0d got %h want %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [W-1:0] got;
    clear_sb();
    mac_tx_ready = 1'b0;
    send_frame(2, 64'h6666_0000_0000_0000, 8'hFF, 1'b0, 1'b1, w);
    send_frame(2, 64'h7777_0000_0000_0000, 8'h3F, 1'b0, 1'b1, w);
    exp_frames += 2;
    wait_valid();
    mac_tx_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      vectors++;
      if (mac_tx_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_valid%0d got %b want 1", s, mac_tx_valid);
      end
    end
    @(posedge clk); #1;
    wait_obs();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : 'x;
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_beat%0d got %h want %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_ordering();
    int w;
    logic [W-1:0] got;
    clear_sb();
    mac_tx_ready = 1'b0;
    drive_beat(64'h0807060504030201, 8'h03, 1'b1, 1'b0, w);
    exp_q.push_back({64'h0807060504030201, 8'h03, 1'b1});
    exp_frames++;
    for (int i = 0; i < 50 && !mac_tx_valid_b; i++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (mac_tx_valid_b !== 1'b1 || mac_tx_b !== 64'h0102030405060708 || mac_tx_keep_b !== 8'hC0) begin
      miscompares++;
      $display("FAIL order_swap got %b/%h/%h want 1/0102030405060708/c0",
               mac_tx_valid_b, mac_tx_b, mac_tx_keep_b);
    end
    vectors++;
    if (mac_tx !== 64'h0807060504030201 || mac_tx_keep !== 8'h03) begin
      miscompares++;
      $display("FAIL order_pass got %h/%h want 0807060504030201/03", mac_tx, mac_tx_keep);
    end
    mac_tx_ready = 1'b1;
    wait_obs();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL order_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    got = (obs_q.size() > 0) ? obs_q[0] : 'x;
    vectors++;
    if (got !== exp_q[0]) begin
      miscompares++;
      $display("FAIL order_beat got %h want %h", got, exp_q[0]);
    end
  endtask

  task automatic test_stats();
    logic [31:0] ef, ed;
`ifdef ZULU_MAC_TX_STAT_EN
    ef = 32'(exp_frames);
    ed = 32'(exp_drops);
`else
    ef = 32'd0;
    ed = 32'd0;
`endif
    vectors++;
    if (stat_tx_frames !== ef || stat_tx_drops !== ed) begin
      miscompares++;
      $display("FAIL stats_count got %0d/%0d want %0d/%0d", stat_tx_frames, stat_tx_drops, ef, ed);
    end
    stat_rst = 1'b1;
    @(posedge clk); #1;
    stat_rst = 1'b0;
    exp_frames = 0;
    exp_drops = 0;
    vectors++;
    if (stat_tx_frames !== 32'd0 || stat_tx_drops !== 32'd0) begin
      miscompares++;
      $display("FAIL stats_clear got %0d/%0d want 0/0", stat_tx_frames, stat_tx_drops);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    int seen;
    logic [W-1:0] got;
    logic [31:0] ef;
    clear_sb();
    mac_tx_ready = 1'b0;
    send_frame(4, 64'h8888_0000_0000_0000, 8'hFF, 1'b0, 1'b0, w);
    wait_valid();
    mac_tx_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (mac_tx_valid !== 1'b0 || tx_level !== 5'd0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_now got valid=%b level=%0d ready=%b want 0/0/0",
               mac_tx_valid, tx_level, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    clear_sb();
    exp_frames = 0;
    exp_drops = 0;
    vectors++;
    if (stat_tx_frames !== 32'd0 || stat_tx_drops !== 32'd0) begin
      miscompares++;
      $display("FAIL rstmid_stats got %0d/%0d want 0/0", stat_tx_frames, stat_tx_drops);
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (mac_tx_valid) seen++;
    end
    @(posedge clk); #1;
    vectors++;
    if (seen != 0 || obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL rstmid_quiet got valid_cycles=%0d beats=%0d want 0/0", seen, obs_q.size());
    end
    send_frame(1, 64'h9999_0000_0000_0000, 8'h0F, 1'b0, 1'b1, w);
    exp_frames++;
    wait_obs();
    got = (obs_q.size() > 0) ? obs_q[0] : 'x;
    vectors++;
    if (obs_q.size() != 1 || got !== exp_q[0]) begin
      miscompares++;
      $display("FAIL rstmid_new got n=%0d %h want n=1 %h", obs_q.size(), got, exp_q[0]);
    end
`ifdef ZULU_MAC_TX_STAT_EN
    ef = 32'(exp_frames);
`else
    ef = 32'd0;
`endif
    vectors++;
    if (stat_tx_frames !== ef) begin
      miscompares++;
      $display("FAIL rstmid_frames got %0d want %0d", stat_tx_frames, ef);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_drop();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_ordering();
    test_stats();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
